// File: rtl/core_ctrl_if.sv
// core_ctrl_if
// Bundles the tile-request, configuration and core-facing signals of the
// core_ctrl instruction sequencer so they travel as one port.
//   start        : one-cycle tile request
//   mode         : 0 = weight-stationary, 1 = output-stationary
//   relu_en      : ReLU on drained outputs
//   acc_en       : accumulate on drained outputs
//   w_base       : activation-SRAM address of the first weight vector
//   x_base       : activation-SRAM address of the first activation vector
//   p_base       : psum-SRAM address of the first output vector
//   n_x          : number of activation (and output) vectors
//   ofifo_valid  : core output FIFO holds at least one entry
//   inst         : 36-bit core instruction word
//   busy         : sequencer is running a tile
//   done         : one-cycle tile-complete pulse
// The master modport is the requesting side; the slave modport is core_ctrl.
interface core_ctrl_if #(
    parameter int addr_bw = 11
);
    logic               start;
    logic               mode;
    logic               relu_en;
    logic               acc_en;
    logic [addr_bw-1:0] w_base;
    logic [addr_bw-1:0] x_base;
    logic [addr_bw-1:0] p_base;
    logic [addr_bw-1:0] n_x;
    logic               ofifo_valid;
    logic [35:0]        inst;
    logic               busy;
    logic               done;

    modport master (
        output start, mode, relu_en, acc_en,
        output w_base, x_base, p_base, n_x,
        output ofifo_valid,
        input  inst, busy, done
    );

    modport slave (
        input  start, mode, relu_en, acc_en,
        input  w_base, x_base, p_base, n_x,
        input  ofifo_valid,
        output inst, busy, done
    );
endinterface

// File: rtl/core_ctrl.sv
// core_ctrl
// Instruction sequencer for the compute core. A single start pulse runs one
// tile: weight preload (weight-stationary only), activation fetch into L0,
// array execution, then draining the output FIFO into psum SRAM.
// Ports:
//   clk    : single clock, all state changes on the rising edge
//   reset  : synchronous, active-high; one clock returns to IDLE
//   bus    : core_ctrl_if slave modport (config, handshake, inst/busy/done)
// Parameters:
//   row     : array rows (activation vector size)
//   col     : array columns; number of weight vectors preloaded
//   addr_bw : SRAM address width for both memories (at most 11)
// The instruction word, busy and done are registered straight from the FSM
// state, so every output lags its state by exactly one cycle and no input
// reaches an output combinationally.
module core_ctrl #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int addr_bw = 11
) (
    input  logic       clk,
    input  logic       reset,
    core_ctrl_if.slave bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_W_RD  = 3'd1;
    localparam logic [2:0] S_W_LD  = 3'd2;
    localparam logic [2:0] S_X_RD  = 3'd3;
    localparam logic [2:0] S_EXEC  = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    // Both SRAMs disabled (CEN=1, WEN=1), everything else low.
    localparam logic [35:0]        IDLE_WORD = 36'h1_800C_0000;
    localparam logic [addr_bw-1:0] CNT_ONE   = addr_bw'(1);
    localparam logic [addr_bw-1:0] COL_LAST  = addr_bw'(col - 1);

    // The address fields in the instruction word are 11 bits wide.
    if (row < 1 || col < 1 || addr_bw > 11) begin : g_bad_params
        $error("core_ctrl: unsupported parameter set");
    end

    logic [2:0]         state;
    logic [2:0]         state_nxt;
    logic [addr_bw-1:0] cnt;
    logic [addr_bw-1:0] rd_cnt;
    logic [addr_bw-1:0] wr_cnt;
    logic [addr_bw-1:0] w_base_q;
    logic [addr_bw-1:0] x_base_q;
    logic [addr_bw-1:0] p_base_q;
    logic [addr_bw-1:0] n_q;
    logic [addr_bw-1:0] n_last;
    logic               mode_q;
    logic               relu_q;
    logic               acc_q;
    logic               wr_pend;
    logic               xrd_q;
    logic               cnt_col_last;
    logic               cnt_n_last;
    logic               xmem_rd;
    logic               ofifo_rd;
    logic               pmem_wr;
    logic [35:0]        inst_nxt;
    logic [35:0]        inst_q;
    logic               busy_q;
    logic               done_q;

    assign bus.inst = inst_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

    // Next-state decode. DRAIN pops the FIFO only while it has data and
    // fewer than N entries have been taken; each pop schedules a psum write
    // for the following cycle, and the tile ends on the N-th write.
    always_comb begin
        n_last       = n_q - CNT_ONE;
        cnt_col_last = (cnt == COL_LAST);
        cnt_n_last   = (cnt == n_last);
        xmem_rd      = (state == S_W_RD) || (state == S_X_RD);
        ofifo_rd     = (state == S_DRAIN) && bus.ofifo_valid && (rd_cnt < n_q);
        pmem_wr      = (state == S_DRAIN) && wr_pend;
        state_nxt    = state;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    if (!bus.mode)
                        state_nxt = S_W_RD;
                    else if (bus.n_x == '0)
                        state_nxt = S_DONE;
                    else
                        state_nxt = S_X_RD;
                end
            end
            S_W_RD:  if (cnt_col_last) state_nxt = S_W_LD;
            S_W_LD:  if (cnt_col_last) state_nxt = (n_q == '0) ? S_DONE : S_X_RD;
            S_X_RD:  if (cnt_n_last) state_nxt = S_EXEC;
            S_EXEC:  if (cnt_n_last) state_nxt = S_DRAIN;
            S_DRAIN: if (pmem_wr && (wr_cnt == n_last)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Instruction word for the current state, registered on the next edge.
    // l0_wr follows every xmem read by one cycle regardless of state, since
    // that is when the read data arrives at L0.
    always_comb begin
        inst_nxt     = IDLE_WORD;
        inst_nxt[2]  = xrd_q;
        inst_nxt[35] = (state != S_IDLE) && mode_q;
        case (state)
            S_W_RD: begin
                inst_nxt[19]          = 1'b0;
                inst_nxt[7 +: addr_bw] = w_base_q + cnt;
            end
            S_W_LD: begin
                inst_nxt[0] = 1'b1;
                inst_nxt[3] = 1'b1;
            end
            S_X_RD: begin
                inst_nxt[19]          = 1'b0;
                inst_nxt[7 +: addr_bw] = x_base_q + cnt;
            end
            S_EXEC: begin
                inst_nxt[1] = 1'b1;
                inst_nxt[3] = 1'b1;
            end
            S_DRAIN: begin
                inst_nxt[6]  = ofifo_rd;
                inst_nxt[33] = acc_q;
                inst_nxt[34] = relu_q;
                if (pmem_wr) begin
                    inst_nxt[32]           = 1'b0;
                    inst_nxt[31]           = 1'b0;
                    inst_nxt[20 +: addr_bw] = p_base_q + wr_cnt;
                end
            end
            default: ;
        endcase
    end

    // State, counters, latched tile configuration and registered outputs.
    // Config is captured only on an accepted start so it stays stable for
    // the whole tile; the drain counters and pending-write flag are cleared
    // whenever the FSM is outside DRAIN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            w_base_q <= '0;
            x_base_q <= '0;
            p_base_q <= '0;
            n_q      <= '0;
            mode_q   <= 1'b0;
            relu_q   <= 1'b0;
            acc_q    <= 1'b0;
            wr_pend  <= 1'b0;
            xrd_q    <= 1'b0;
            inst_q   <= IDLE_WORD;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            inst_q <= inst_nxt;
            busy_q <= (state != S_IDLE);
            done_q <= (state == S_DONE);
            xrd_q  <= xmem_rd;

            if (state == S_IDLE && bus.start) begin
                mode_q   <= bus.mode;
                relu_q   <= bus.relu_en;
                acc_q    <= bus.acc_en;
                w_base_q <= bus.w_base;
                x_base_q <= bus.x_base;
                p_base_q <= bus.p_base;
                n_q      <= bus.n_x;
            end

            if (state_nxt != state)
                cnt <= '0;
            else if (state == S_W_RD || state == S_W_LD ||
                     state == S_X_RD || state == S_EXEC)
                cnt <= cnt + CNT_ONE;

            if (state == S_DRAIN) begin
                wr_pend <= ofifo_rd;
                if (ofifo_rd)
                    rd_cnt <= rd_cnt + CNT_ONE;
                if (pmem_wr)
                    wr_cnt <= wr_cnt + CNT_ONE;
            end else begin
                wr_pend <= 1'b0;
                rd_cnt  <= '0;
                wr_cnt  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl
// Directed testbench for core_ctrl. Each tile is launched with a start
// pulse, every busy cycle's instruction word is recorded, and the recording
// is compared against hand-computed expectations: exact words for the
// reference weight-stationary tile, and counts/address lists for the rest.
module tb_core_ctrl;

    localparam logic [35:0] IDLE_WORD = 36'h1_800C_0000;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    core_ctrl_if #(.addr_bw(11)) bus ();

    core_ctrl #(.row(8), .col(8), .addr_bw(11)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [35:0] trace [$];
    logic [10:0] xaddr [$];
    logic [10:0] paddr [$];
    int          done_at;
    int          n_done;
    int          n_xrd, n_kload, n_exec, n_ofrd, n_pcen, n_mode1, n_relu, pair_err;
    logic [35:0] post_inst;
    logic        post_busy;
    logic        post_done;

    task automatic checkOutput(input string tag, input logic [63:0] got,
                               input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Hand-written word sequence for: mode 0, col 8, N 4, w_base 0,
    // x_base 16, p_base 100, acc_en 1, relu_en 0, ofifo_valid always high.
    function automatic logic [35:0] expWordT1(input int c);
        logic [35:0] w;
        w = IDLE_WORD;
        if (c <= 8) begin
            w[19]   = 1'b0;
            w[17:7] = 11'(c - 1);
            w[2]    = (c >= 2);
        end else if (c <= 16) begin
            w[0] = 1'b1;
            w[3] = 1'b1;
            w[2] = (c == 9);
        end else if (c <= 20) begin
            w[19]   = 1'b0;
            w[17:7] = 11'(16 + c - 17);
            w[2]    = (c >= 18);
        end else if (c <= 24) begin
            w[1] = 1'b1;
            w[3] = 1'b1;
            w[2] = (c == 21);
        end else if (c <= 29) begin
            w[33] = 1'b1;
            w[6]  = (c <= 28);
            if (c >= 26) begin
                w[32]    = 1'b0;
                w[31]    = 1'b0;
                w[30:20] = 11'(100 + c - 26);
            end
        end
        return w;
    endfunction

    // Launch one tile, scramble the config inputs right after start, and
    // record every busy cycle until done (bounded). valid_pat 1 drives
    // ofifo_valid as 1,0,0 repeating; poke pulses start with a different
    // config as soon as the first ofifo_rd is seen.
    task automatic applyStimulus(input logic m, input logic relu, input logic acc,
                                 input logic [10:0] wb, input logic [10:0] xb,
                                 input logic [10:0] pb, input logic [10:0] n,
                                 input int valid_pat, input bit poke);
        int cyc;
        int poke_state;
        bit got_done;
        @(posedge clk); #1;
        bus.mode        = m;
        bus.relu_en     = relu;
        bus.acc_en      = acc;
        bus.w_base      = wb;
        bus.x_base      = xb;
        bus.p_base      = pb;
        bus.n_x         = n;
        bus.ofifo_valid = 1'b1;
        bus.start       = 1'b1;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.mode    = ~m;
        bus.relu_en = ~relu;
        bus.acc_en  = ~acc;
        bus.w_base  = wb ^ 11'h155;
        bus.x_base  = xb ^ 11'h2AA;
        bus.p_base  = pb ^ 11'h0F0;
        bus.n_x     = n + 11'd5;
        trace.delete();
        done_at    = -1;
        n_done     = 0;
        cyc        = 0;
        poke_state = 0;
        got_done   = 1'b0;
        while (!got_done && cyc < 500) begin
            @(negedge clk);
            if (bus.busy) begin
                trace.push_back(bus.inst);
                if (bus.done) begin
                    n_done++;
                    done_at  = trace.size() - 1;
                    got_done = 1'b1;
                end
            end
            if (poke && poke_state == 0 && bus.inst[6])
                poke_state = 1;
            @(posedge clk); #1;
            if (valid_pat == 1)
                bus.ofifo_valid = ((cyc % 3) == 0);
            else
                bus.ofifo_valid = 1'b1;
            if (poke_state == 1) begin
                bus.start  = 1'b1;
                bus.mode   = 1'b0;
                bus.n_x    = 11'd7;
                bus.p_base = 11'd500;
                poke_state = 2;
            end else if (poke_state == 2) begin
                bus.start  = 1'b0;
                poke_state = 3;
            end
            cyc++;
        end
        if (!got_done)
            checkOutput("tile_timeout", 64'd0, 64'd1);
        @(negedge clk);
        post_inst = bus.inst;
        post_busy = bus.busy;
        post_done = bus.done;
        bus.ofifo_valid = 1'b1;
    endtask

    // Reduce the recorded words to counts and address lists; pair_err counts
    // pops without a write one cycle later and writes without a pop before.
    task automatic analyzeTrace();
        logic [35:0] w;
        n_xrd = 0; n_kload = 0; n_exec = 0; n_ofrd = 0;
        n_pcen = 0; n_mode1 = 0; n_relu = 0; pair_err = 0;
        xaddr.delete();
        paddr.delete();
        foreach (trace[i]) begin
            w = trace[i];
            if (!w[19] && w[18]) begin
                n_xrd++;
                xaddr.push_back(w[17:7]);
            end
            if (w[0])  n_kload++;
            if (w[1])  n_exec++;
            if (!w[32]) n_pcen++;
            if (w[35]) n_mode1++;
            if (w[34]) n_relu++;
            if (w[6]) begin
                n_ofrd++;
                if (i + 1 >= trace.size())
                    pair_err++;
                else if (trace[i+1][32] || trace[i+1][31])
                    pair_err++;
            end
            if (!w[32] && !w[31]) begin
                paddr.push_back(w[30:20]);
                if (i == 0)
                    pair_err++;
                else if (!trace[i-1][6])
                    pair_err++;
            end
        end
    endtask

    task automatic checkAddrList(input string tag, input logic [10:0] got [$],
                                 input logic [10:0] first, input int count);
        logic [10:0] e;
        checkOutput({tag, "_count"}, 64'(got.size()), 64'(count));
        e = first;
        for (int k = 0; k < count && k < got.size(); k++) begin
            checkOutput($sformatf("%s[%0d]", tag, k), 64'(got[k]), 64'(e));
            e = e + 11'd1;
        end
    endtask

    initial begin
        bool_init: begin
            bus.start       = 1'b0;
            bus.mode        = 1'b0;
            bus.relu_en     = 1'b0;
            bus.acc_en      = 1'b0;
            bus.w_base      = '0;
            bus.x_base      = '0;
            bus.p_base      = '0;
            bus.n_x         = '0;
            bus.ofifo_valid = 1'b1;
        end

        // Reset values
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_inst", 64'(bus.inst), 64'(IDLE_WORD));
        checkOutput("reset_busy", 64'(bus.busy), 64'd0);
        checkOutput("reset_done", 64'(bus.done), 64'd0);

        // Reference weight-stationary tile, exact words
        $display("[TB] tile 1: mode 0, col 8, N 4");
        applyStimulus(1'b0, 1'b0, 1'b1, 11'd0, 11'd16, 11'd100, 11'd4, 0, 1'b0);
        checkOutput("t1_length", 64'(trace.size()), 64'd30);
        checkOutput("t1_done_at", 64'(done_at), 64'd29);
        for (int c = 1; c <= 30 && c <= trace.size(); c++)
            checkOutput($sformatf("t1_word[%0d]", c), 64'(trace[c-1]), 64'(expWordT1(c)));
        checkOutput("t1_post_inst", 64'(post_inst), 64'(IDLE_WORD));
        checkOutput("t1_post_busy", 64'(post_busy), 64'd0);
        checkOutput("t1_post_done", 64'(post_done), 64'd0);

        // Output-stationary tile
        $display("[TB] tile 2: mode 1, N 3");
        applyStimulus(1'b1, 1'b1, 1'b0, 11'd0, 11'd5, 11'd7, 11'd3, 0, 1'b0);
        analyzeTrace();
        checkOutput("t2_length", 64'(trace.size()), 64'd11);
        checkOutput("t2_done_at", 64'(done_at), 64'd10);
        checkOutput("t2_kload", 64'(n_kload), 64'd0);
        checkOutput("t2_mode_bit", 64'(n_mode1), 64'd11);
        checkOutput("t2_exec", 64'(n_exec), 64'd3);
        checkOutput("t2_relu", 64'(n_relu), 64'd4);
        checkOutput("t2_pair_err", 64'(pair_err), 64'd0);
        checkAddrList("t2_xaddr", xaddr, 11'd5, 3);
        checkAddrList("t2_paddr", paddr, 11'd7, 3);

        // Drain with ofifo_valid stalling
        $display("[TB] tile 3: drain stalls");
        applyStimulus(1'b1, 1'b0, 1'b0, 11'd0, 11'd0, 11'd200, 11'd4, 1, 1'b0);
        analyzeTrace();
        checkOutput("t3_done_last", 64'(done_at), 64'(trace.size() - 1));
        checkOutput("t3_ofifo_rd", 64'(n_ofrd), 64'd4);
        checkOutput("t3_pair_err", 64'(pair_err), 64'd0);
        checkAddrList("t3_paddr", paddr, 11'd200, 4);

        // Empty tile in weight-stationary mode
        $display("[TB] tile 4: n_x = 0");
        applyStimulus(1'b0, 1'b0, 1'b0, 11'd40, 11'd0, 11'd0, 11'd0, 0, 1'b0);
        analyzeTrace();
        checkOutput("t4_length", 64'(trace.size()), 64'd17);
        checkOutput("t4_kload", 64'(n_kload), 64'd8);
        checkOutput("t4_exec", 64'(n_exec), 64'd0);
        checkOutput("t4_pmem_cen", 64'(n_pcen), 64'd0);
        checkAddrList("t4_xaddr", xaddr, 11'd40, 8);

        // Address wrap
        $display("[TB] tile 5: x_base wrap");
        applyStimulus(1'b1, 1'b0, 1'b0, 11'd0, 11'd2046, 11'd0, 11'd4, 0, 1'b0);
        analyzeTrace();
        checkOutput("t5_length", 64'(trace.size()), 64'd14);
        checkAddrList("t5_xaddr", xaddr, 11'd2046, 4);

        // Reset during EXEC
        $display("[TB] tile 6: reset during EXEC");
        begin
            bit seen;
            @(posedge clk); #1;
            bus.mode   = 1'b0;
            bus.n_x    = 11'd4;
            bus.x_base = 11'd16;
            bus.p_base = 11'd100;
            bus.start  = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
            seen = 1'b0;
            for (int k = 0; k < 100 && !seen; k++) begin
                @(negedge clk);
                if (bus.inst[1]) seen = 1'b1;
            end
            checkOutput("t6_exec_seen", 64'(seen), 64'd1);
            @(posedge clk); #1;
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            @(negedge clk);
            checkOutput("t6_inst", 64'(bus.inst), 64'(IDLE_WORD));
            checkOutput("t6_busy", 64'(bus.busy), 64'd0);
            checkOutput("t6_done", 64'(bus.done), 64'd0);
            repeat (3) @(negedge clk);
            checkOutput("t6_stays_idle", 64'(bus.busy), 64'd0);
        end

        // Start pulsed during DRAIN is ignored
        $display("[TB] tile 7: start during DRAIN");
        applyStimulus(1'b1, 1'b0, 1'b0, 11'd0, 11'd9, 11'd50, 11'd3, 0, 1'b1);
        analyzeTrace();
        checkOutput("t7_length", 64'(trace.size()), 64'd11);
        checkOutput("t7_mode_bit", 64'(n_mode1), 64'd11);
        checkAddrList("t7_paddr", paddr, 11'd50, 3);
        checkOutput("t7_post_busy", 64'(post_busy), 64'd0);
        repeat (3) @(negedge clk);
        checkOutput("t7_stays_idle", 64'(bus.busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
        $finish;
    end

endmodule
